// File: rtl/axi4_slv_dual_fsm_pkg.sv
// axi4_slv_pkg: shared burst/response/FSM types and burst legality helper for the dual-FSM AXI4 slave
package axi4_slv_pkg;
  localparam int LEN_W = 8;
  localparam int SIZE_W = 3;
  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11} axi4_burst_t;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} axi4_resp_t;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_fsm_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_fsm_t;
  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [SIZE_W-1:0] size;
    axi4_burst_t burst;
  } axi4_req_t;
  function automatic logic burst_illegal(input axi4_burst_t burst, input logic [LEN_W-1:0] len);
    return burst == RSVD || (burst == WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction
endpackage

// File: rtl/axi4_slv_dual_fsm_if.sv
// axi4_slv_dual_fsm_if: AXI4 bus bundle between interconnect master and the dual-FSM slave
interface axi4_slv_dual_fsm_if #(
  parameter int ID_WIDTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0] awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic [USER_WIDTH-1:0] awuser;
  logic awvalid;
  logic awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic wlast;
  logic [USER_WIDTH-1:0] wuser;
  logic wvalid;
  logic wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0] bresp;
  logic [USER_WIDTH-1:0] buser;
  logic bvalid;
  logic bready;
  logic [ID_WIDTH-1:0] arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic [USER_WIDTH-1:0] aruser;
  logic arvalid;
  logic arready;
  logic [ID_WIDTH-1:0] rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic [USER_WIDTH-1:0] ruser;
  logic rvalid;
  logic rready;
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awuser, awvalid,
    input wdata, wstrb, wlast, wuser, wvalid, bready,
    input arid, araddr, arlen, arsize, arburst, aruser, arvalid, rready,
    output awready, wready, bid, bresp, buser, bvalid,
    output arready, rid, rdata, rresp, rlast, ruser, rvalid
  );
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awuser, awvalid,
    output wdata, wstrb, wlast, wuser, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, aruser, arvalid, rready,
    input awready, wready, bid, bresp, buser, bvalid,
    input arready, rid, rdata, rresp, rlast, ruser, rvalid
  );
endinterface

// File: rtl/axi4_slv_dual_fsm_addr_gen.sv
// axi4_burst_addr_gen: next in-page byte address for FIXED/INCR/WRAP bursts; only bits [11:0] move so INCR never leaves the 4 KB page
module axi4_burst_addr_gen
  import axi4_slv_pkg::*;
(
  input  logic [11:0]       addr_i,
  input  logic [SIZE_W-1:0] size_i,
  input  logic [LEN_W-1:0]  len_i,
  input  axi4_burst_t       burst_i,
  output logic [11:0]       next_o
);
  logic [11:0] incr, mask;
  // WRAP keeps the bits above the (len+1)<<size window and wraps the offset inside it
  always_comb begin
    incr = addr_i + (12'd1 << size_i);
    mask = (({4'd0, len_i} + 12'd1) << size_i) - 12'd1;
    next_o = burst_i == FIXED ? addr_i : burst_i == WRAP ? (addr_i & ~mask) | (incr & mask) : incr;
  end
endmodule

// File: rtl/axi4_slv_dual_fsm.sv
// axi4_slv_dual_fsm: AXI4 slave with independent read/write FSMs driving an SRAM-style word port
module axi4_slv_dual_fsm
  import axi4_slv_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int USR_ADDR_SIZE = 64 * 1024 * 1024,
  localparam int UA = $clog2(USR_ADDR_SIZE),
  localparam int OFF = $clog2(DATA_WIDTH / 8),
  localparam int WA = UA - OFF
)(
  input  logic                    aclk,
  input  logic                    aresetn,
  axi4_slv_dual_fsm_if.slave      axi,
  output logic                    usr_wr_en_o,
  output logic [WA-1:0]           usr_wr_addr_o,
  output logic [DATA_WIDTH/8-1:0] usr_wr_bm_o,
  output logic [DATA_WIDTH-1:0]   usr_wr_dat_o,
  output logic                    usr_rd_en_o,
  output logic [WA-1:0]           usr_rd_addr_o,
  input  logic [DATA_WIDTH-1:0]   usr_rd_dat_i
);
  logic rst_done_q;
  wr_fsm_t wr_st_q;
  axi4_req_t wr_req_q;
  logic [UA-1:0] wr_addr_q;
  logic [7:0] wr_cnt_q;
  logic err_w_q;
  logic [ID_WIDTH-1:0] bid_q;
  logic [USER_WIDTH-1:0] buser_q;
  logic [11:0] wr_lo_d;
  rd_fsm_t rd_st_q;
  axi4_req_t rd_req_q;
  logic [UA-1:0] rd_addr_q;
  logic [7:0] rd_cnt_q;
  logic err_r_q;
  logic [ID_WIDTH-1:0] rid_q;
  logic [USER_WIDTH-1:0] ruser_q;
  logic [11:0] rd_lo_d;
  logic aw_hs, w_hs, ar_hs, rd_last, err_aw, err_ar;

  axi4_burst_addr_gen u_wr_gen (.addr_i(wr_addr_q[11:0]), .size_i(wr_req_q.size), .len_i(wr_req_q.len), .burst_i(wr_req_q.burst), .next_o(wr_lo_d));
  axi4_burst_addr_gen u_rd_gen (.addr_i(rd_addr_q[11:0]), .size_i(rd_req_q.size), .len_i(rd_req_q.len), .burst_i(rd_req_q.burst), .next_o(rd_lo_d));

  assign err_aw = (axi.awaddr >> UA) != '0 || burst_illegal(axi4_burst_t'(axi.awburst), axi.awlen);
  assign err_ar = (axi.araddr >> UA) != '0 || burst_illegal(axi4_burst_t'(axi.arburst), axi.arlen);
  assign axi.awready = rst_done_q && wr_st_q == WR_IDLE;
  assign axi.wready = wr_st_q == WR_DATA;
  assign axi.bvalid = wr_st_q == WR_RESP;
  assign axi.bid = bid_q;
  assign axi.buser = buser_q;
  assign axi.bresp = axi.bvalid && err_w_q ? SLVERR : OKAY;
  assign axi.arready = rst_done_q && rd_st_q == RD_IDLE;
  assign axi.rvalid = rd_st_q == RD_DATA;
  assign axi.rid = rid_q;
  assign axi.ruser = ruser_q;
  assign axi.rresp = axi.rvalid && err_r_q ? SLVERR : OKAY;
  assign axi.rdata = axi.rvalid && !err_r_q ? usr_rd_dat_i : '0;
  assign rd_last = rd_cnt_q == rd_req_q.len;
  assign axi.rlast = axi.rvalid && rd_last;
  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs = axi.wvalid && axi.wready;
  assign ar_hs = axi.arvalid && axi.arready;
  assign usr_wr_en_o = w_hs && !err_w_q;
  assign usr_wr_addr_o = wr_addr_q[UA-1:OFF];
  assign usr_wr_bm_o = usr_wr_en_o ? axi.wstrb : '0;
  assign usr_wr_dat_o = usr_wr_en_o ? axi.wdata : '0;
  assign usr_rd_en_o = ar_hs ? !err_ar : axi.rvalid && axi.rready && !rd_last && !err_r_q;
  assign usr_rd_addr_o = ar_hs ? axi.araddr[UA-1:OFF] : {rd_addr_q[UA-1:12], rd_lo_d[11:OFF]};

  // Reset-release flop: address channels open one cycle after aresetn rises
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) rst_done_q <= 1'b0;
    else rst_done_q <= 1'b1;

  // Write FSM: capture AW, stream W beats to the user port, then return B
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      wr_st_q <= WR_IDLE;
      wr_req_q <= '0;
      wr_addr_q <= '0;
      wr_cnt_q <= '0;
      err_w_q <= 1'b0;
      bid_q <= '0;
      buser_q <= '0;
    end else begin
      case (wr_st_q)
        WR_IDLE: if (aw_hs) begin
          wr_st_q <= WR_DATA;
          wr_req_q <= '{len: axi.awlen, size: axi.awsize, burst: axi4_burst_t'(axi.awburst)};
          wr_addr_q <= axi.awaddr[UA-1:0];
          wr_cnt_q <= '0;
          err_w_q <= err_aw;
          bid_q <= axi.awid;
          buser_q <= axi.awuser;
        end
        WR_DATA: if (w_hs) begin
          wr_addr_q[11:0] <= wr_lo_d;
          wr_cnt_q <= wr_cnt_q + 8'd1;
          if (axi.wlast) begin
            wr_st_q <= WR_RESP;
            if (wr_cnt_q != wr_req_q.len) err_w_q <= 1'b1;
          end
        end
        WR_RESP: if (axi.bready) wr_st_q <= WR_IDLE;
        default: wr_st_q <= WR_IDLE;
      endcase
    end

  // Read FSM: fetch is issued on AR and on every accepted non-last beat, so R streams one beat per cycle
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      rd_st_q <= RD_IDLE;
      rd_req_q <= '0;
      rd_addr_q <= '0;
      rd_cnt_q <= '0;
      err_r_q <= 1'b0;
      rid_q <= '0;
      ruser_q <= '0;
    end else begin
      case (rd_st_q)
        RD_IDLE: if (ar_hs) begin
          rd_st_q <= RD_DATA;
          rd_req_q <= '{len: axi.arlen, size: axi.arsize, burst: axi4_burst_t'(axi.arburst)};
          rd_addr_q <= axi.araddr[UA-1:0];
          rd_cnt_q <= '0;
          err_r_q <= err_ar;
          rid_q <= axi.arid;
          ruser_q <= axi.aruser;
        end
        RD_DATA: if (axi.rready) begin
          if (rd_last) rd_st_q <= RD_IDLE;
          else begin
            rd_cnt_q <= rd_cnt_q + 8'd1;
            rd_addr_q[11:0] <= rd_lo_d;
          end
        end
        default: rd_st_q <= RD_IDLE;
      endcase
    end
endmodule

// File: tb/tb_axi4_slv_dual_fsm.sv
// tb_axi4_slv_dual_fsm: directed AXI4 bursts with a queue-based scoreboard of user-port and response traffic
module tb_axi4_slv_dual_fsm;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi4_slv_dual_fsm_if axi ();
  logic usr_wr_en, usr_rd_en;
  logic [22:0] usr_wr_addr, usr_rd_addr;
  logic [7:0] usr_wr_bm;
  logic [63:0] usr_wr_dat;
  logic [63:0] rd_dat = '0;

  axi4_slv_dual_fsm dut (
    .aclk(aclk), .aresetn(aresetn), .axi(axi),
    .usr_wr_en_o(usr_wr_en), .usr_wr_addr_o(usr_wr_addr), .usr_wr_bm_o(usr_wr_bm), .usr_wr_dat_o(usr_wr_dat),
    .usr_rd_en_o(usr_rd_en), .usr_rd_addr_o(usr_rd_addr), .usr_rd_dat_i(rd_dat)
  );

  typedef struct {logic [22:0] addr; logic [7:0] bm; logic [63:0] dat;} wr_exp_t;
  typedef struct {logic [3:0] id; logic [63:0] dat; logic [1:0] resp; logic last;} r_exp_t;
  typedef struct {logic [3:0] id; logic [1:0] resp;} b_exp_t;
  wr_exp_t wq[$];
  r_exp_t rq[$];
  b_exp_t bq[$];
  logic [22:0] raq[$];
  wr_exp_t we;
  r_exp_t re;
  b_exp_t be;
  logic [22:0] ra;
  int errors = 0, checks = 0, cyc = 0, r_beats = 0;
  int wr_first = -1, wr_last = -1, r_first = -1, r_last = -1;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [22:0] a);
    return {8'hA5, 1'b0, a, 9'h15A, a};
  endfunction

  function automatic logic tb_err(input logic [31:0] a, input int len, input logic [1:0] burst);
    return a >= 32'h0400_0000 || burst == 2'b11 || (burst == 2'b10 && len != 1 && len != 3 && len != 7 && len != 15);
  endfunction

  function automatic logic [22:0] word_of(input logic [31:0] a);
    return a[25:3];
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i, input int size, input int len, input logic [1:0] burst);
    logic [31:0] nb, tot, b;
    nb = 32'd1 << size;
    tot = 32'(len + 1) * nb;
    b = a - (a % tot);
    if (burst == 2'b00) return a;
    if (burst == 2'b10) return b + ((a - b + 32'(i) * nb) % tot);
    return (a & ~32'hFFF) | ((a + 32'(i) * nb) & 32'hFFF);
  endfunction

  always @(posedge aclk) if (usr_rd_en) rd_dat <= pat(usr_rd_addr);

  always @(negedge aclk) begin
    cyc++;
    if (mon_en) begin
      if (usr_wr_en) begin
        if (wq.size() == 0) chk("wr_unexpected", 64'(usr_wr_en), 64'd0);
        else begin
          we = wq.pop_front();
          chk("wr_addr", 64'(usr_wr_addr), 64'(we.addr));
          chk("wr_bm", 64'(usr_wr_bm), 64'(we.bm));
          chk("wr_dat", usr_wr_dat, we.dat);
        end
        if (wr_first < 0) wr_first = cyc;
        wr_last = cyc;
      end
      if (usr_rd_en) begin
        if (raq.size() == 0) chk("rd_en_unexpected", 64'(usr_rd_en), 64'd0);
        else begin
          ra = raq.pop_front();
          chk("rd_addr", 64'(usr_rd_addr), 64'(ra));
        end
      end
      if (axi.rvalid) begin
        if (rq.size() == 0) chk("r_unexpected", 64'(axi.rvalid), 64'd0);
        else begin
          re = rq[0];
          chk("rid", 64'(axi.rid), 64'(re.id));
          chk("rdata", axi.rdata, re.dat);
          chk("rresp", 64'(axi.rresp), 64'(re.resp));
          chk("rlast", 64'(axi.rlast), 64'(re.last));
          if (axi.rready) begin
            void'(rq.pop_front());
            r_beats++;
            if (r_first < 0) r_first = cyc;
            r_last = cyc;
          end
        end
      end
      if (axi.bvalid && axi.bready) begin
        if (bq.size() == 0) chk("b_unexpected", 64'(axi.bvalid), 64'd0);
        else begin
          be = bq.pop_front();
          chk("bid", 64'(axi.bid), 64'(be.id));
          chk("bresp", 64'(axi.bresp), 64'(be.resp));
        end
      end
    end
  end

  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input int len, input int size, input logic [1:0] burst, input int nb, output int aw_wait);
    logic [63:0] dat[$];
    logic [7:0] stb[$];
    logic bad;
    bad = tb_err(a, len, burst);
    for (int i = 0; i < nb; i++) begin
      dat.push_back({$urandom, $urandom});
      stb.push_back(8'($urandom_range(1, 255)));
      if (!bad) wq.push_back('{word_of(beat_addr(a, i, size, len, burst)), stb[i], dat[i]});
    end
    bq.push_back('{id, (bad || nb != len + 1) ? 2'b10 : 2'b00});
    aw_wait = 0;
    fork
      begin
        logic hs;
        hs = 1'b0;
        axi.awvalid = 1'b1; axi.awid = id; axi.awaddr = a; axi.awlen = 8'(len); axi.awsize = 3'(size); axi.awburst = burst; axi.awuser = 1'b1;
        for (int t = 0; t < 50 && !hs; t++) begin
          @(negedge aclk); hs = axi.awready;
          if (!hs) aw_wait++;
          @(posedge aclk); #1;
        end
        chk("aw_handshake", 64'(hs), 64'd1);
        axi.awvalid = 1'b0;
      end
      begin
        for (int i = 0; i < nb; i++) begin
          logic hs;
          hs = 1'b0;
          axi.wvalid = 1'b1; axi.wdata = dat[i]; axi.wstrb = stb[i]; axi.wlast = (i == nb - 1);
          for (int t = 0; t < 50 && !hs; t++) begin
            @(negedge aclk); hs = axi.wready;
            @(posedge aclk); #1;
          end
          chk("w_handshake", 64'(hs), 64'd1);
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        @(negedge aclk); chk("bvalid_after_wlast", 64'(axi.bvalid), 64'd1);
        @(posedge aclk); #1;
      end
    join
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input int len, input int size, input logic [1:0] burst, input bit toggle, output int ar_wait);
    logic bad, hs;
    int target;
    bad = tb_err(a, len, burst);
    for (int i = 0; i <= len; i++) begin
      if (!bad) raq.push_back(word_of(beat_addr(a, i, size, len, burst)));
      rq.push_back('{id, bad ? 64'd0 : pat(word_of(beat_addr(a, i, size, len, burst))), bad ? 2'b10 : 2'b00, i == len});
    end
    target = r_beats + len + 1;
    ar_wait = 0;
    hs = 1'b0;
    axi.arvalid = 1'b1; axi.arid = id; axi.araddr = a; axi.arlen = 8'(len); axi.arsize = 3'(size); axi.arburst = burst; axi.aruser = 1'b0;
    for (int t = 0; t < 50 && !hs; t++) begin
      @(negedge aclk); hs = axi.arready;
      if (!hs) ar_wait++;
      @(posedge aclk); #1;
    end
    chk("ar_handshake", 64'(hs), 64'd1);
    axi.arvalid = 1'b0;
    for (int k = 0; k < 200 && r_beats < target; k++) begin
      axi.rready = toggle ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
      @(posedge aclk); #1;
    end
    axi.rready = 1'b0;
    chk("r_beat_count", 64'(r_beats), 64'(target));
    chk("rd_fetch_left", 64'(raq.size()), 64'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_awready"}, 64'(axi.awready), 64'd0);
    chk({tag, "_wready"}, 64'(axi.wready), 64'd0);
    chk({tag, "_bvalid"}, 64'(axi.bvalid), 64'd0);
    chk({tag, "_bresp"}, 64'(axi.bresp), 64'd0);
    chk({tag, "_arready"}, 64'(axi.arready), 64'd0);
    chk({tag, "_rvalid"}, 64'(axi.rvalid), 64'd0);
    chk({tag, "_rlast"}, 64'(axi.rlast), 64'd0);
    chk({tag, "_rdata"}, axi.rdata, 64'd0);
    chk({tag, "_wr_en"}, 64'(usr_wr_en), 64'd0);
    chk({tag, "_wr_addr"}, 64'(usr_wr_addr), 64'd0);
    chk({tag, "_wr_dat"}, usr_wr_dat, 64'd0);
    chk({tag, "_rd_en"}, 64'(usr_rd_en), 64'd0);
    chk({tag, "_rd_addr"}, 64'(usr_rd_addr), 64'd0);
  endtask

  task automatic release_reset();
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("awready_gated", 64'(axi.awready), 64'd0);
    chk("arready_gated", 64'(axi.arready), 64'd0);
    @(negedge aclk);
    chk("awready_open", 64'(axi.awready), 64'd1);
    chk("arready_open", 64'(axi.arready), 64'd1);
    chk("wready_idle", 64'(axi.wready), 64'd0);
    chk("rvalid_idle", 64'(axi.rvalid), 64'd0);
    @(posedge aclk); #1;
  endtask

  initial begin
    #500000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  initial begin
    int aw_w, ar_w;
    axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0; axi.awuser = 0;
    axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.wuser = 0; axi.bready = 1;
    axi.arvalid = 0; axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0; axi.aruser = 0; axi.rready = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk_outputs_zero("por");
    release_reset();
    mon_en = 1'b1;

    wr_first = -1;
    do_write(4'h3, 32'h100, 3, 3, 2'b01, 4, aw_w);
    chk("incr_wr_span", 64'(wr_last - wr_first), 64'd3);

    r_first = -1;
    do_read(4'h5, 32'h118, 3, 3, 2'b10, 1'b0, ar_w);
    chk("wrap_rd_span", 64'(r_last - r_first), 64'd3);

    do_read(4'h6, 32'h118, 3, 3, 2'b10, 1'b1, ar_w);

    do_read(4'h7, 32'h0400_0000, 1, 3, 2'b01, 1'b0, ar_w);
    do_write(4'h8, 32'h0400_0000, 1, 3, 2'b01, 2, aw_w);
    do_read(4'h9, 32'h200, 2, 3, 2'b10, 1'b0, ar_w);

    do_write(4'hA, 32'h300, 3, 3, 2'b01, 2, aw_w);

    wr_first = -1; r_first = -1;
    fork
      do_write(4'hB, 32'h800, 7, 3, 2'b01, 8, aw_w);
      do_read(4'hC, 32'h400, 7, 3, 2'b01, 1'b0, ar_w);
    join
    chk("aw_wait", 64'(aw_w), 64'd0);
    chk("ar_wait", 64'(ar_w), 64'd0);
    chk("conc_wr_span", 64'(wr_last - wr_first), 64'd7);
    chk("conc_rd_span", 64'(r_last - r_first), 64'd7);

    mon_en = 1'b0;
    axi.awvalid = 1; axi.awaddr = 32'h1000; axi.awlen = 8'd7; axi.awsize = 3'd3; axi.awburst = 2'b01;
    axi.arvalid = 1; axi.araddr = 32'h1800; axi.arlen = 8'd7; axi.arsize = 3'd3; axi.arburst = 2'b01;
    axi.wvalid = 1; axi.wdata = 64'hDEAD_BEEF_0123_4567; axi.wstrb = 8'hFF; axi.rready = 1;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    axi.awvalid = 0; axi.arvalid = 0; axi.wvalid = 0; axi.rready = 0;
    release_reset();
    mon_en = 1'b1;

    do_write(4'hD, 32'h40, 2, 3, 2'b00, 3, aw_w);
    do_read(4'hE, 32'h40, 2, 3, 2'b00, 1'b0, ar_w);
    do_read(4'h1, 32'h10, 1, 3, 2'b11, 1'b0, ar_w);

    chk("wq_left", 64'(wq.size()), 64'd0);
    chk("rq_left", 64'(rq.size()), 64'd0);
    chk("bq_left", 64'(bq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
